// File: rtl/controlador_es_if.sv
// rtl/controlador_es_if.sv - I/O controller bundle between the MIPS core and board I/O
// Purpose: groups the input-wait and print-instruction signals of controlador_es.
// Ports (master = core/board side, slave = controlador_es):
//   Req_Entrada, Entrada_lida[IN_W], Confirma_Entrada, Sinal_Ext   master -> slave
//   Req_Saida, Canal_Saida[CH_W], Dado_Saida[DATA_W]              master -> slave
//   Stall, Dado_Entrada[DATA_W], Entrada_Valida, LED_Wait          slave  -> master
//   Saidas[N_OUT*DATA_W], Saida_Atualizada[N_OUT]                  slave  -> master
interface controlador_es_if #(
  parameter int DATA_W = 32,
  parameter int IN_W   = 16,
  parameter int CH_W   = 1
);
  localparam int N_OUT = 1 << CH_W;

  logic                    Req_Entrada;
  logic [IN_W-1:0]         Entrada_lida;
  logic                    Confirma_Entrada;
  logic                    Sinal_Ext;
  logic                    Req_Saida;
  logic [CH_W-1:0]         Canal_Saida;
  logic [DATA_W-1:0]       Dado_Saida;
  logic                    Stall;
  logic [DATA_W-1:0]       Dado_Entrada;
  logic                    Entrada_Valida;
  logic [N_OUT*DATA_W-1:0] Saidas;
  logic [N_OUT-1:0]        Saida_Atualizada;
  logic                    LED_Wait;

  modport master (
    output Req_Entrada, Entrada_lida, Confirma_Entrada, Sinal_Ext,
    output Req_Saida, Canal_Saida, Dado_Saida,
    input  Stall, Dado_Entrada, Entrada_Valida, Saidas, Saida_Atualizada, LED_Wait
  );

  modport slave (
    input  Req_Entrada, Entrada_lida, Confirma_Entrada, Sinal_Ext,
    input  Req_Saida, Canal_Saida, Dado_Saida,
    output Stall, Dado_Entrada, Entrada_Valida, Saidas, Saida_Atualizada, LED_Wait
  );
endinterface

// File: rtl/controlador_es.sv
// rtl/controlador_es.sv - stall-based input/output controller for the MIPS core
// Purpose: waits for the user button by stalling the core (no clock gating), captures
// and extends the switch value as a one-cycle register-file write, and latches print
// values into N_OUT output channels.
// Optional macro DEBOUNCE_EN: adds a DEB_CYC-cycle stability filter on the button.
// Ports:
//   Clock    rising-edge system clock
//   Reset_n  asynchronous active-low reset
//   io       controlador_es_if.slave bundle (input wait, print, status outputs)
module controlador_es #(
  parameter int DATA_W  = 32,
  parameter int IN_W    = 16,
  parameter int CH_W    = 1,
  parameter int DEB_CYC = 8
) (
  input logic               Clock,
  input logic               Reset_n,
  controlador_es_if.slave   io
);
  localparam int N_OUT = 1 << CH_W;

  typedef enum logic [1:0] {OCIOSO, ESPERA_SOLTAR, ESPERA, ENTREGA} state_t;

  state_t                  state_q, state_d;
  logic                    sync1_q, sync2_q, conf_prev_q;
  logic                    conf_s, press;
  logic [DATA_W-1:0]       ext_val;
  logic [DATA_W-1:0]       dado_entrada_q, dado_entrada_d;
  logic [N_OUT*DATA_W-1:0] saidas_q, saidas_d;
  logic [N_OUT-1:0]        saida_atualizada_q, saida_atualizada_d;

`ifdef DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEB_CYC) + 1;

  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d, deb_cnt_inc;
  logic             deb_lvl_q, deb_lvl_d;

  // Counter runs only while the synchronised level disagrees with the filtered one;
  // any return to agreement restarts it, so short bounces never flip the level.
  always_comb begin
    deb_cnt_inc = deb_cnt_q + 1'b1;
    deb_cnt_d   = '0;
    deb_lvl_d   = deb_lvl_q;
    if (sync2_q != deb_lvl_q) begin
      if (deb_cnt_inc == CNT_W'(DEB_CYC)) begin
        deb_lvl_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_inc;
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      deb_cnt_q <= '0;
      deb_lvl_q <= 1'b1;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      deb_lvl_q <= deb_lvl_d;
    end
  end

  assign conf_s = deb_lvl_q;
`else
  assign conf_s = sync2_q;
`endif

  assign press = conf_s & ~conf_prev_q;

  always_comb begin
    ext_val = '0;
    ext_val[IN_W-1:0] = io.Entrada_lida;
    if (io.Sinal_Ext && io.Entrada_lida[IN_W-1]) begin
      for (int i = IN_W; i < DATA_W; i++) begin
        ext_val[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    dado_entrada_d = dado_entrada_q;
    case (state_q)
      OCIOSO: begin
        // A button still held from an earlier input must be released first.
        if (io.Req_Entrada) state_d = conf_s ? ESPERA_SOLTAR : ESPERA;
      end
      ESPERA_SOLTAR: begin
        if (!io.Req_Entrada) state_d = OCIOSO;
        else if (!conf_s)    state_d = ESPERA;
      end
      ESPERA: begin
        if (!io.Req_Entrada) begin
          state_d = OCIOSO;
        end else if (press) begin
          state_d        = ENTREGA;
          dado_entrada_d = ext_val;
        end
      end
      default: state_d = OCIOSO;
    endcase

    // Output channels are independent of the input FSM and ignore Stall.
    saidas_d           = saidas_q;
    saida_atualizada_d = '0;
    if (io.Req_Saida) begin
      saidas_d[io.Canal_Saida*DATA_W +: DATA_W] = io.Dado_Saida;
      saida_atualizada_d[io.Canal_Saida]        = 1'b1;
    end
  end

  // Synchroniser and edge history reset high so a button held through reset is not a press.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q            <= OCIOSO;
      sync1_q            <= 1'b1;
      sync2_q            <= 1'b1;
      conf_prev_q        <= 1'b1;
      dado_entrada_q     <= '0;
      saidas_q           <= '0;
      saida_atualizada_q <= '0;
    end else begin
      state_q            <= state_d;
      sync1_q            <= io.Confirma_Entrada;
      sync2_q            <= sync1_q;
      conf_prev_q        <= conf_s;
      dado_entrada_q     <= dado_entrada_d;
      saidas_q           <= saidas_d;
      saida_atualizada_q <= saida_atualizada_d;
    end
  end

  // Stall drops in ENTREGA so the PC advances on the same edge as the register write.
  assign io.Stall            = io.Req_Entrada & (state_q != ENTREGA);
  assign io.Entrada_Valida   = (state_q == ENTREGA);
  assign io.LED_Wait         = (state_q == ESPERA) | (state_q == ESPERA_SOLTAR);
  assign io.Dado_Entrada     = dado_entrada_q;
  assign io.Saidas           = saidas_q;
  assign io.Saida_Atualizada = saida_atualizada_q;
endmodule

// File: tb/tb_controlador_es.sv
// tb/tb_controlador_es.sv - scoreboard testbench for controlador_es
module tb_controlador_es;
  localparam int DATA_W  = 32;
  localparam int IN_W    = 16;
  localparam int CH_W    = 1;
  localparam int DEB_CYC = 8;
  localparam int N_OUT   = 1 << CH_W;
`ifdef DEBOUNCE_EN
  localparam int DEB = DEB_CYC;
`else
  localparam int DEB = 0;
`endif
  localparam int SETTLE = DEB + 6;
  localparam int LAT_LO = 3 + DEB;
  localparam int LAT_HI = 4 + DEB;

  typedef struct {
    int                ch;
    logic [DATA_W-1:0] d;
  } out_t;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  int   valid_count = 0;

  logic [DATA_W-1:0] exp_in[$];
  out_t              exp_out[$];
  logic [DATA_W-1:0] chan_val[N_OUT];

  controlador_es_if #(.DATA_W(DATA_W), .IN_W(IN_W), .CH_W(CH_W)) io ();

  controlador_es #(.DATA_W(DATA_W), .IN_W(IN_W), .CH_W(CH_W), .DEB_CYC(DEB_CYC)) dut (
    .Clock   (clk),
    .Reset_n (rst_n),
    .io      (io)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  // Reference: two's-complement sign extension is modular subtraction of 2^IN_W.
  function automatic logic [DATA_W-1:0] ref_ext(input logic [IN_W-1:0] d, input logic s);
    logic [DATA_W-1:0] r;
    r = DATA_W'(d);
    if (s && (d >= (IN_W)'(1 << (IN_W - 1)))) r = r - DATA_W'(64'd1 << IN_W);
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_switches(input logic [IN_W-1:0] d, input logic s);
    io.Entrada_lida = d;
    io.Sinal_Ext    = s;
    exp_in.push_back(ref_ext(d, s));
  endtask

  task automatic press_wait(input bit drop_req);
    int cyc;
    bit got;
    cyc = 0;
    got = 1'b0;
    io.Confirma_Entrada = 1'b1;
    while (!got && cyc < LAT_HI + 6) begin
      @(posedge clk);
      #1;
      cyc++;
      if (io.Entrada_Valida) got = 1'b1;
    end
    check("valida_seen", 64'(got), 64'd1);
    if (got) begin
      check_rng("press_to_valida", cyc, LAT_LO, LAT_HI);
      check("stall_in_entrega", 64'(io.Stall), 64'd0);
    end
    if (drop_req) io.Req_Entrada = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    out_t             o;
    logic [DATA_W-1:0] e;
    logic [N_OUT-1:0]  oh;
    if (rst_n) begin
      if (io.Entrada_Valida) begin
        valid_count++;
        if (exp_in.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valida actual=1 required=0 dado=%h", io.Dado_Entrada);
        end else begin
          e = exp_in.pop_front();
          check("dado_entrada", 64'(io.Dado_Entrada), 64'(e));
        end
      end
      if (io.Saida_Atualizada != '0) begin
        if (exp_out.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_update actual=%b required=0", io.Saida_Atualizada);
        end else begin
          o = exp_out.pop_front();
          chan_val[o.ch] = o.d;
          oh = '0;
          oh[o.ch] = 1'b1;
          check("saida_pulse", 64'(io.Saida_Atualizada), 64'(oh));
          for (int k = 0; k < N_OUT; k++) begin
            check($sformatf("saidas_ch%0d", k), 64'(io.Saidas[k*DATA_W +: DATA_W]), 64'(chan_val[k]));
          end
        end
      end
    end
  end

  initial begin
    int vc;
    logic [DATA_W-1:0] held;
    for (int k = 0; k < N_OUT; k++) chan_val[k] = '0;
    rst_n               = 1'b0;
    io.Req_Entrada      = 1'b0;
    io.Entrada_lida     = '0;
    io.Confirma_Entrada = 1'b1;
    io.Sinal_Ext        = 1'b0;
    io.Req_Saida        = 1'b0;
    io.Canal_Saida      = '0;
    io.Dado_Saida       = '0;
    tick(3);
    check("rst_stall", 64'(io.Stall), 64'd0);
    check("rst_led", 64'(io.LED_Wait), 64'd0);
    check("rst_valida", 64'(io.Entrada_Valida), 64'd0);
    check("rst_dado", 64'(io.Dado_Entrada), 64'd0);
    check("rst_saidas", 64'(io.Saidas), 64'd0);
    check("rst_upd", 64'(io.Saida_Atualizada), 64'd0);
    rst_n = 1'b1;
    tick(2);

    // Button held through reset: request must wait for release.
    io.Req_Entrada = 1'b1;
    #1;
    check("stall_first_cycle", 64'(io.Stall), 64'd1);
    tick(4);
    check("led_espera_soltar", 64'(io.LED_Wait), 64'd1);
    check("stall_espera_soltar", 64'(io.Stall), 64'd1);
    check("no_valida_held", 64'(valid_count), 64'd0);
    io.Confirma_Entrada = 1'b0;
    tick(SETTLE);
    check("led_espera", 64'(io.LED_Wait), 64'd1);
    load_switches(16'h8001, 1'b1);
    press_wait(1'b1);
    check("dado_sext", 64'(io.Dado_Entrada), 64'h0000_0000_FFFF_8001);
    io.Confirma_Entrada = 1'b0;
    tick(SETTLE);

    // Zero-extend, button held for 20 cycles gives one strobe.
    vc = valid_count;
    io.Req_Entrada = 1'b1;
    tick(2);
    load_switches(16'h8001, 1'b0);
    press_wait(1'b1);
    check("dado_zext", 64'(io.Dado_Entrada), 64'h0000_0000_0000_8001);
    tick(20);
    check("one_valida_held", 64'(valid_count - vc), 64'd1);
    check("led_idle", 64'(io.LED_Wait), 64'd0);
    io.Confirma_Entrada = 1'b0;
    tick(SETTLE);

    // Back-to-back requests: second needs release and fresh press.
    vc = valid_count;
    io.Req_Entrada = 1'b1;
    tick(2);
    load_switches(16'(($urandom)), 1'b1);
    press_wait(1'b0);
    tick(10);
    check("b2b_wait_release", 64'(valid_count - vc), 64'd1);
    check("b2b_led", 64'(io.LED_Wait), 64'd1);
    io.Confirma_Entrada = 1'b0;
    tick(SETTLE);
    check("b2b_still_wait", 64'(valid_count - vc), 64'd1);
    load_switches(16'(($urandom)), 1'b0);
    press_wait(1'b1);
    io.Confirma_Entrada = 1'b0;
    tick(SETTLE);
    check("b2b_two_valida", 64'(valid_count - vc), 64'd2);

    // Abort mid-ESPERA.
    vc = valid_count;
    io.Req_Entrada = 1'b1;
    tick(SETTLE);
    held = io.Dado_Entrada;
    io.Entrada_lida = ~io.Entrada_lida;
    io.Req_Entrada = 1'b0;
    #1;
    check("abort_stall", 64'(io.Stall), 64'd0);
    tick(1);
    check("abort_led", 64'(io.LED_Wait), 64'd0);
    tick(5);
    check("abort_dado_held", 64'(io.Dado_Entrada), 64'(held));
    check("abort_no_valida", 64'(valid_count - vc), 64'd0);

    // Randomised input transactions.
    for (int i = 0; i < 6; i++) begin
      io.Req_Entrada = 1'b1;
      tick($urandom_range(0, 3));
      load_switches(16'($urandom), 1'($urandom));
      press_wait(1'b1);
      tick($urandom_range(1, 6));
      io.Confirma_Entrada = 1'b0;
      tick(SETTLE);
    end

    // Directed print to channel 1, then a print while stalled.
    io.Req_Saida = 1'b1;
    io.Canal_Saida = CH_W'(1);
    io.Dado_Saida = 32'h0000_00A5;
    exp_out.push_back('{1, 32'h0000_00A5});
    tick(1);
    io.Req_Saida = 1'b0;
    check("print_upd", 64'(io.Saida_Atualizada), 64'b10);
    check("print_ch1", 64'(io.Saidas[63:32]), 64'hA5);
    check("print_ch0_hold", 64'(io.Saidas[31:0]), 64'd0);
    tick(1);
    check("print_pulse_end", 64'(io.Saida_Atualizada), 64'd0);
    io.Req_Entrada = 1'b1;
    io.Req_Saida = 1'b1;
    io.Canal_Saida = CH_W'(0);
    io.Dado_Saida = 32'h1234_563C;
    exp_out.push_back('{0, 32'h1234_563C});
    #1;
    check("print_stalled", 64'(io.Stall), 64'd1);
    tick(1);
    io.Req_Saida = 1'b0;
    check("print_stall_ch0", 64'(io.Saidas[31:0]), 64'h1234_563C);
    check("print_stall_ch1", 64'(io.Saidas[63:32]), 64'hA5);
    io.Req_Entrada = 1'b0;
    tick(2);

    // Randomised print bursts, some while stalled.
    for (int i = 0; i < 20; i++) begin
      int ch;
      int len;
      logic [DATA_W-1:0] d;
      ch = $urandom_range(0, N_OUT - 1);
      len = $urandom_range(1, 3);
      io.Req_Entrada = 1'($urandom);
      for (int j = 0; j < len; j++) begin
        d = $urandom;
        io.Req_Saida = 1'b1;
        io.Canal_Saida = CH_W'(ch);
        io.Dado_Saida = d;
        exp_out.push_back('{ch, d});
        tick(1);
      end
      io.Req_Saida = 1'b0;
      tick($urandom_range(0, 2));
    end
    io.Req_Entrada = 1'b0;
    tick(3);

`ifdef DEBOUNCE_EN
    vc = valid_count;
    io.Req_Entrada = 1'b1;
    tick(SETTLE);
    io.Confirma_Entrada = 1'b1;
    tick(5);
    io.Confirma_Entrada = 1'b0;
    tick(SETTLE + 5);
    check("deb_glitch_ignored", 64'(valid_count - vc), 64'd0);
    load_switches(16'($urandom), 1'b1);
    io.Confirma_Entrada = 1'b1;
    tick(12);
    io.Confirma_Entrada = 1'b0;
    io.Req_Entrada = 1'b0;
    tick(SETTLE + 5);
    check("deb_one_capture", 64'(valid_count - vc), 64'd1);
`endif

    tick(3);
    check("in_queue_drained", 64'(exp_in.size()), 64'd0);
    check("out_queue_drained", 64'(exp_out.size()), 64'd0);
    for (int k = 0; k < N_OUT; k++) begin
      check($sformatf("final_ch%0d", k), 64'(io.Saidas[k*DATA_W +: DATA_W]), 64'(chan_val[k]));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/controlador_es.md
Name: controlador_es

Overview:
- Parametrised input/output controller for the MIPS core.
- Replaces the gated-clock input wait with a stall request.
- Input side: synchronises the Confirma_Entrada button, captures switch data and delivers it as a one-cycle write to the register file.
- Output side: drives N latched output channels (display/LEDs) selected by the print instruction.
- Sits between the control unit/register file and board I/O; the core clock is never gated.

Parameters:
- DATA_W, 32: register-file data width.
- IN_W, 16: switch input width; IN_W <= DATA_W.
- CH_W, 1: output channel select width; N_OUT = 2^CH_W channels.
- DEB_CYC, 8: debounce stability count in cycles; used only with DEBOUNCE_EN.

Ports:
- Clock  in  1  system clock, all logic on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Req_Entrada  in  1  input instruction in decode (Esperar_Entrada).
- Entrada_lida  in  IN_W  switch data, quasi-static.
- Confirma_Entrada  in  1  raw button, asynchronous, active-high.
- Sinal_Ext  in  1  1 = sign-extend input, 0 = zero-extend.
- Req_Saida  in  1  print instruction this cycle.
- Canal_Saida  in  CH_W  target output channel.
- Dado_Saida  in  DATA_W  value to print (Rs).
- Stall  out  1  hold PC and block register writes.
- Dado_Entrada  out  DATA_W  captured, extended input.
- Entrada_Valida  out  1  one-cycle register-file write strobe.
- Saidas  out  N_OUT*DATA_W  latched channels; channel k at bits [k*DATA_W +: DATA_W].
- Saida_Atualizada  out  N_OUT  one-cycle update pulse per channel.
- LED_Wait  out  1  waiting for user.

Behaviour:
- Reset (async, Reset_n=0):
  - state=OCIOSO.
  - Dado_Entrada=0, Saidas=0, Entrada_Valida=0, Saida_Atualizada=0.
  - Synchroniser and edge-history flops reset to 1, so a button held through reset is not a press.
- Confirma_Entrada passes through a 2-flop synchroniser giving conf_s.
- Press = conf_s & ~conf_prev (rising edge).
- FSM (registered state):
  - OCIOSO: if Req_Entrada: conf_s=1 -> ESPERA_SOLTAR, else -> ESPERA.
  - ESPERA_SOLTAR: conf_s=0 -> ESPERA. Button must be released before a press counts.
  - ESPERA: press -> ENTREGA. On the same edge, Dado_Entrada <= extend(Entrada_lida):
    - Sinal_Ext=1: replicate bit IN_W-1.
    - Sinal_Ext=0: zero-fill.
  - ENTREGA: Entrada_Valida=1 for exactly this cycle -> OCIOSO.
  - Req_Entrada=0 in ESPERA or ESPERA_SOLTAR (flush/abort): -> OCIOSO, no Entrada_Valida, Dado_Entrada unchanged.
- Stall = Req_Entrada & (state != ENTREGA).
  - Combinational, so the first request cycle already stalls.
  - Deasserts in ENTREGA so the PC advances on the same edge the register write happens.
- Back-to-back input instructions:
  - The second request is seen in OCIOSO the cycle after ENTREGA.
  - It needs a fresh press; the still-held button routes through ESPERA_SOLTAR.
- LED_Wait = (state==ESPERA) | (state==ESPERA_SOLTAR). Registered-state decode, no glitch.
- Latency: capture 1 cycle after press detection; press detection 2–3 cycles after the raw edge.
- Output path (independent of the FSM):
  - When Req_Saida=1, on the next edge Saidas[Canal_Saida] <= Dado_Saida and Saida_Atualizada[Canal_Saida]=1 for one cycle.
  - Other channels hold.
  - Simultaneous Req_Saida and Stall: the write still happens.
  - Req_Saida held for several cycles: the channel rewrites and pulses every cycle.
- Entrada_lida is not synchronised; it must be stable while waiting (user-set switches).

Optional Feature:
- Macro DEBOUNCE_EN.
- Defined: conf_s only changes after the synchronised input has been stable for DEB_CYC consecutive cycles. Counter is $clog2(DEB_CYC)+1 bits, reset to 0 with the debounced level reset to 1. Bounces shorter than DEB_CYC cycles produce no press.
- Undefined: no counter; conf_s is the raw 2-flop synchroniser output.

Test Plan:
1. Reset with Confirma_Entrada=1, then Req_Entrada=1:
   - state goes to ESPERA_SOLTAR, Stall=1, LED_Wait=1.
   - Release, then press with Entrada_lida=16'h8001, Sinal_Ext=1 -> Dado_Entrada=32'hFFFF8001 with a one-cycle Entrada_Valida, Stall low in that cycle.
2. Req_Entrada=1, button idle, press with Entrada_lida=16'h8001, Sinal_Ext=0:
   - Dado_Entrada=32'h00008001.
   - Press-to-Valida latency of 3–4 cycles.
   - Exactly one Valida pulse even with the button held for 20 cycles.
3. Two consecutive input requests with the button held after the first:
   - The second waits in ESPERA_SOLTAR and captures only after release and a new press.
4. Req_Entrada dropped mid-ESPERA -> OCIOSO, Stall=0, no Valida, Dado_Entrada unchanged.
5. CH_W=1: Req_Saida with channel 1, Dado_Saida=32'h0000_00A5:
   - Saidas[63:32]=32'hA5, Saida_Atualizada=2'b10 for one cycle, channel 0 unchanged.
   - Repeat while Stall=1 -> the write still occurs.
6. DEBOUNCE_EN, DEB_CYC=8: a 5-cycle glitch gives no press; a 12-cycle press gives exactly one capture.
